stack_mem_ctrl: RTL and testbench



---
 rtl/stack_mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_stack_mem_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/stack_mem_ctrl.sv
// Parametrised downward-growing stack memory with push/pop/exchange, windowed
// load/store, direct SP load, occupancy status and sticky error flags.
module stack_mem_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              stack_op,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [31:0]             address,
  input  logic                    mem_re,
  input  logic                    mem_we,
  input  logic                    update_sp,
  input  logic [31:0]             new_sp,
  input  logic                    err_clr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic [31:0]             sp,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    ovf_err,
  output logic                    udf_err,
  output logic                    addr_err
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = IDX_W + 1;
  localparam logic [31:0] TOP_ADDR = BASE_ADDR + 32'(DEPTH) * 32'd4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_XCHG = 2'b01,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b11
  } op_e;

  logic [DATA_W-1:0] mem [DEPTH];

  op_e              op;
  logic [31:0]      sp_next;
  logic             wr_en, rd_en;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             set_ovf, set_udf, set_addr;
  logic             win_req, win_ok, sp_ok;

  function automatic logic [IDX_W-1:0] idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

  assign op      = op_e'(stack_op);
  assign empty   = (sp == TOP_ADDR);
  assign full    = (sp == BASE_ADDR);
  assign count   = CNT_W'((TOP_ADDR - sp) >> 2);
  assign win_req = mem_re | mem_we;
  // A window access must fall inside the live stack, i.e. [sp, TOP_ADDR).
  assign win_ok  = (address[1:0] == 2'b00) && (address >= sp) && (address < TOP_ADDR);
  assign sp_ok   = (new_sp[1:0] == 2'b00) && (new_sp >= BASE_ADDR) && (new_sp <= TOP_ADDR);

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    sp_next  = sp;
    wr_en    = 1'b0;
    wr_idx   = '0;
    rd_en    = 1'b0;
    rd_idx   = '0;
    set_ovf  = 1'b0;
    set_udf  = 1'b0;
    set_addr = 1'b0;
    if (update_sp) begin
      if (sp_ok) sp_next = new_sp;
      else       set_addr = 1'b1;
      if (op != OP_IDLE || win_req) set_addr = 1'b1;
    end else if (op != OP_IDLE) begin
      if (win_req) set_addr = 1'b1;
      case (op)
        OP_PUSH: begin
          if (full) set_ovf = 1'b1;
          else begin
            wr_en   = 1'b1;
            wr_idx  = idx(sp - 32'd4);
            sp_next = sp - 32'd4;
          end
        end
        OP_POP: begin
          if (empty) set_udf = 1'b1;
          else begin
            rd_en   = 1'b1;
            rd_idx  = idx(sp);
            sp_next = sp + 32'd4;
          end
        end
        OP_XCHG: begin
          if (empty) set_udf = 1'b1;
          else begin
            rd_en  = 1'b1;
            rd_idx = idx(sp);
            wr_en  = 1'b1;
            wr_idx = idx(sp);
          end
        end
        OP_IDLE: ;
      endcase
    end else if (win_req) begin
      if (!win_ok) set_addr = 1'b1;
      else begin
        rd_en  = mem_re;
        rd_idx = idx(address);
        wr_en  = mem_we;
        wr_idx = idx(address);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so the same-edge read
  // of mem sees the old word (exchange and read-before-write rely on this).
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp       <= TOP_ADDR;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf_err  <= 1'b0;
      udf_err  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      sp       <= sp_next;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_idx];
      // A new error outranks a simultaneous clear.
      ovf_err  <= set_ovf  | (ovf_err  & ~err_clr);
      udf_err  <= set_udf  | (udf_err  & ~err_clr);
      addr_err <= set_addr | (addr_err & ~err_clr);
    end
  end

  // NOTE: the storage array has no reset; it is only blocked from writing
  // during a reset cycle, which keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_idx] <= wr_data;
  end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed-vector bench for stack_mem_ctrl with DEPTH=4 at base 0x3000.
module tb_stack_mem_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        stack_op;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       address;
  logic              mem_re, mem_we, update_sp, err_clr;
  logic [31:0]       new_sp;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [31:0]       sp;
  logic [2:0]        count;
  logic              full, empty, ovf_err, udf_err, addr_err;

  int tests_run    = 0;
  int tests_failed = 0;

  stack_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .stack_op(stack_op), .wr_data(wr_data), .address(address),
    .mem_re(mem_re), .mem_we(mem_we), .update_sp(update_sp), .new_sp(new_sp),
    .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid), .sp(sp), .count(count),
    .full(full), .empty(empty), .ovf_err(ovf_err), .udf_err(udf_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    stack_op = 2'b00; wr_data = '0; address = '0; mem_re = 0; mem_we = 0;
    update_sp = 0; new_sp = '0; err_clr = 0;
  endtask

  // Apply the currently driven inputs for one edge, then sample away from it.
  task automatic step();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic op(input logic [1:0] code, input logic [31:0] data);
    stack_op = code; wr_data = data; step();
  endtask

  task automatic clear_errs();
    err_clr = 1; step();
    tests_run++; if ({ovf_err, udf_err, addr_err} !== 3'b000) begin tests_failed++; $display("FAIL err_clr flags got %b exp 000", {ovf_err, udf_err, addr_err}); end
  endtask

  task automatic test_reset();
    rst = 0; idle(); step(); step(); rst = 1;
    tests_run++; if (sp !== 32'h3010) begin tests_failed++; $display("FAIL reset_sp got %h exp 00003010", sp); end
    tests_run++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin tests_failed++; $display("FAIL reset_status got count=%0d empty=%b full=%b exp 0 1 0", count, empty, full); end
    tests_run++; if (rd_data !== 32'h0 || rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd got %h/%b exp 0/0", rd_data, rd_valid); end
    tests_run++; if ({ovf_err, udf_err, addr_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b exp 000", {ovf_err, udf_err, addr_err}); end
  endtask

  task automatic test_fill();
    logic [31:0] exp_sp [4] = '{32'h300C, 32'h3008, 32'h3004, 32'h3000};
    logic [31:0] vals   [4] = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 4; i++) begin
      op(2'b10, vals[i]);
      tests_run++; if (sp !== exp_sp[i]) begin tests_failed++; $display("FAIL fill_sp[%0d] got %h exp %h", i, sp, exp_sp[i]); end
    end
    tests_run++; if (count !== 3'd4 || full !== 1'b1 || empty !== 1'b0) begin tests_failed++; $display("FAIL fill_status got count=%0d full=%b empty=%b exp 4 1 0", count, full, empty); end
    op(2'b10, 32'hA5);
    tests_run++; if (ovf_err !== 1'b1 || sp !== 32'h3000) begin tests_failed++; $display("FAIL overflow got ovf=%b sp=%h exp 1 00003000", ovf_err, sp); end
    clear_errs();
  endtask

  task automatic test_drain();
    logic [31:0] exp_d [4] = '{32'hA4, 32'hA3, 32'hA2, 32'hA1};
    for (int i = 0; i < 4; i++) begin
      op(2'b11, '0);
      tests_run++; if (rd_data !== exp_d[i] || rd_valid !== 1'b1) begin tests_failed++; $display("FAIL drain[%0d] got %h/%b exp %h/1", i, rd_data, rd_valid, exp_d[i]); end
    end
    step();
    tests_run++; if (rd_valid !== 1'b0 || rd_data !== 32'hA1) begin tests_failed++; $display("FAIL drain_hold got %h/%b exp 000000a1/0", rd_data, rd_valid); end
    tests_run++; if (empty !== 1'b1 || count !== 3'd0 || sp !== 32'h3010) begin tests_failed++; $display("FAIL drain_empty got empty=%b count=%0d sp=%h", empty, count, sp); end
    op(2'b11, '0);
    tests_run++; if (udf_err !== 1'b1 || rd_valid !== 1'b0 || sp !== 32'h3010) begin tests_failed++; $display("FAIL underflow got udf=%b rv=%b sp=%h exp 1 0 00003010", udf_err, rd_valid, sp); end
    clear_errs();
  endtask

  task automatic test_exchange();
    op(2'b01, 32'h99);
    tests_run++; if (udf_err !== 1'b1 || rd_valid !== 1'b0) begin tests_failed++; $display("FAIL xchg_empty got udf=%b rv=%b exp 1 0", udf_err, rd_valid); end
    clear_errs();
    op(2'b10, 32'h11);
    op(2'b01, 32'h22);
    tests_run++; if (rd_data !== 32'h11 || rd_valid !== 1'b1 || sp !== 32'h300C) begin tests_failed++; $display("FAIL xchg got %h/%b sp=%h exp 00000011/1 0000300c", rd_data, rd_valid, sp); end
    op(2'b11, '0);
    tests_run++; if (rd_data !== 32'h22 || rd_valid !== 1'b1 || sp !== 32'h3010) begin tests_failed++; $display("FAIL xchg_pop got %h/%b sp=%h exp 00000022/1 00003010", rd_data, rd_valid, sp); end
  endtask

  task automatic test_window();
    op(2'b10, 32'h01); op(2'b10, 32'h02); op(2'b10, 32'h03);
    tests_run++; if (sp !== 32'h3004) begin tests_failed++; $display("FAIL win_sp got %h exp 00003004", sp); end
    address = 32'h3008; wr_data = 32'h55; mem_we = 1; step();
    tests_run++; if (rd_valid !== 1'b0 || addr_err !== 1'b0) begin tests_failed++; $display("FAIL win_store got rv=%b ae=%b exp 0 0", rd_valid, addr_err); end
    address = 32'h3008; mem_re = 1; step();
    tests_run++; if (rd_data !== 32'h55 || rd_valid !== 1'b1) begin tests_failed++; $display("FAIL win_load got %h/%b exp 00000055/1", rd_data, rd_valid); end
    address = 32'h3000; mem_re = 1; step();
    tests_run++; if (addr_err !== 1'b1 || rd_valid !== 1'b0) begin tests_failed++; $display("FAIL win_below got ae=%b rv=%b exp 1 0", addr_err, rd_valid); end
    clear_errs();
    address = 32'h3006; mem_re = 1; step();
    tests_run++; if (addr_err !== 1'b1 || rd_valid !== 1'b0) begin tests_failed++; $display("FAIL win_misalign got ae=%b rv=%b exp 1 0", addr_err, rd_valid); end
    clear_errs();
    address = 32'h3010; mem_re = 1; err_clr = 1; step();
    tests_run++; if (addr_err !== 1'b1 || rd_valid !== 1'b0) begin tests_failed++; $display("FAIL win_top_vs_clr got ae=%b rv=%b exp 1 0", addr_err, rd_valid); end
    clear_errs();
    address = 32'h3004; wr_data = 32'h77; mem_re = 1; mem_we = 1; step();
    tests_run++; if (rd_data !== 32'h03 || rd_valid !== 1'b1) begin tests_failed++; $display("FAIL win_rbw_old got %h/%b exp 00000003/1", rd_data, rd_valid); end
    address = 32'h3004; mem_re = 1; step();
    tests_run++; if (rd_data !== 32'h77) begin tests_failed++; $display("FAIL win_rbw_new got %h exp 00000077", rd_data); end
  endtask

  task automatic test_priority();
    update_sp = 1; new_sp = 32'h3008; stack_op = 2'b10; wr_data = 32'hDEAD; step();
    tests_run++; if (sp !== 32'h3008 || addr_err !== 1'b1 || count !== 3'd2) begin tests_failed++; $display("FAIL prio_sp_push got sp=%h ae=%b count=%0d exp 00003008 1 2", sp, addr_err, count); end
    clear_errs();
    update_sp = 1; new_sp = 32'h3014; step();
    tests_run++; if (sp !== 32'h3008 || addr_err !== 1'b1) begin tests_failed++; $display("FAIL sp_above_top got sp=%h ae=%b exp 00003008 1", sp, addr_err); end
    clear_errs();
    update_sp = 1; new_sp = 32'h3002; step();
    tests_run++; if (sp !== 32'h3008 || addr_err !== 1'b1) begin tests_failed++; $display("FAIL sp_misalign got sp=%h ae=%b exp 00003008 1", sp, addr_err); end
    clear_errs();
    stack_op = 2'b11; address = 32'h300C; mem_re = 1; step();
    tests_run++; if (rd_data !== 32'h55 || rd_valid !== 1'b1 || sp !== 32'h300C || addr_err !== 1'b1) begin tests_failed++; $display("FAIL prio_pop_load got %h/%b sp=%h ae=%b exp 00000055/1 0000300c 1", rd_data, rd_valid, sp, addr_err); end
    clear_errs();
    update_sp = 1; new_sp = 32'h3010; step();
    tests_run++; if (sp !== 32'h3010 || empty !== 1'b1 || addr_err !== 1'b0) begin tests_failed++; $display("FAIL sp_to_top got sp=%h empty=%b ae=%b exp 00003010 1 0", sp, empty, addr_err); end
  endtask

  task automatic test_reset_mid();
    address = 32'h3000; mem_re = 1; step();
    op(2'b10, 32'hB1);
    rst = 0; stack_op = 2'b10; wr_data = 32'hB2; step(); rst = 1;
    tests_run++; if (sp !== 32'h3010 || rd_valid !== 1'b0 || {ovf_err, udf_err, addr_err} !== 3'b000) begin tests_failed++; $display("FAIL rst_mid got sp=%h rv=%b flags=%b exp 00003010 0 000", sp, rd_valid, {ovf_err, udf_err, addr_err}); end
    update_sp = 1; new_sp = 32'h3008; step();
    address = 32'h3008; mem_re = 1; step();
    tests_run++; if (rd_data !== 32'h55 || rd_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_mem got %h/%b exp 00000055/1", rd_data, rd_valid); end
    address = 32'h300C; mem_re = 1; step();
    tests_run++; if (rd_data !== 32'hB1) begin tests_failed++; $display("FAIL rst_keeps_mem got %h exp 000000b1", rd_data); end
  endtask

  initial begin
    rst = 0;
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_exchange();
    test_window();
    test_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
